// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the two requester ports and the block-RAM port of the memory
//   arbiter into one interface.
//
//   Modports:
//     slave  - the arbiter's view: takes requests and memory read data, and
//              drives grants, read returns, memory commands and busy.
//     master - the surrounding system's view (CPU path, peripheral path and
//              the RAM instance).
//
//   Signals:
//     pN_req/pN_we/pN_addr/pN_wdata   request from port N (N = 0 CPU, 1 periph)
//     pN_gnt                          one-cycle command-accepted pulse
//     pN_rvalid/pN_rdata              read return pulse and held read data
//     mem_en/mem_we/mem_addr/mem_wdata  single-port RAM command
//     mem_rdata                       RAM read data, one cycle after command
//     busy                            arbiter not idle
interface mem_port_arbiter_if #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 16
);
  logic                 p0_req;
  logic                 p0_we;
  logic [ADDR_BITS-1:0] p0_addr;
  logic [WIDTH-1:0]     p0_wdata;
  logic                 p0_gnt;
  logic                 p0_rvalid;
  logic [WIDTH-1:0]     p0_rdata;

  logic                 p1_req;
  logic                 p1_we;
  logic [ADDR_BITS-1:0] p1_addr;
  logic [WIDTH-1:0]     p1_wdata;
  logic                 p1_gnt;
  logic                 p1_rvalid;
  logic [WIDTH-1:0]     p1_rdata;

  logic                 mem_en;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [WIDTH-1:0]     mem_wdata;
  logic [WIDTH-1:0]     mem_rdata;

  logic                 busy;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_rdata,
    output p0_gnt, p0_rvalid, p0_rdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output mem_rdata,
    input  p0_gnt, p0_rvalid, p0_rdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port, 1-cycle-read-latency block RAM between the CPU
//   path (port 0) and the peripheral/display path (port 1). Each access runs
//   through IDLE -> ISSUE -> DATA; read data is returned to the port that
//   owned the access with a one-cycle rvalid pulse.
//
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous reset, active low
//     bus    mem_port_arbiter_if.slave (requesters, RAM port, busy)
//
//   Optional feature:
//     MEM_ARB_RR_EN - when defined, simultaneous requests are resolved
//     round-robin (the port that did not win last time wins). When not
//     defined, port 0 always wins a tie.
module mem_port_arbiter #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 16
) (
  input logic              clk,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2
  } state_t;

  state_t state, state_next;

  logic                 owner;
  logic                 cmd_we;
  logic                 grant;
  logic                 grant_sel;
  logic                 sel_we;
  logic [ADDR_BITS-1:0] sel_addr;
  logic [WIDTH-1:0]     sel_wdata;

  logic                 p0_gnt_q, p1_gnt_q;
  logic                 p0_rvalid_q, p1_rvalid_q;
  logic [WIDTH-1:0]     p0_rdata_q, p1_rdata_q;
  logic                 mem_en_q, mem_we_q;
  logic [ADDR_BITS-1:0] mem_addr_q;
  logic [WIDTH-1:0]     mem_wdata_q;

`ifdef MEM_ARB_RR_EN
  logic                 last_winner;
`endif

  // Arbitration happens whenever the RAM is free to take a new command,
  // which is in IDLE and also in DATA (so a new access overlaps the read
  // return of the previous one, giving one access every two cycles).
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    grant_sel  = 1'b0;
    case (state)
      IDLE, DATA: begin
        if (bus.p0_req || bus.p1_req) begin
          state_next = ISSUE;
          grant      = 1'b1;
          if (bus.p0_req && bus.p1_req) begin
`ifdef MEM_ARB_RR_EN
            grant_sel = ~last_winner;
`else
            grant_sel = 1'b0;
`endif
          end else begin
            grant_sel = bus.p1_req;
          end
        end else begin
          state_next = IDLE;
        end
      end
      ISSUE:   state_next = DATA;
      default: state_next = IDLE;
    endcase
  end

  // Command fields of whichever port wins this cycle.
  assign sel_we    = grant_sel ? bus.p1_we    : bus.p0_we;
  assign sel_addr  = grant_sel ? bus.p1_addr  : bus.p0_addr;
  assign sel_wdata = grant_sel ? bus.p1_wdata : bus.p0_wdata;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Registered outputs. Pulses default low every cycle. Leaving DATA with a
  // read in flight captures the RAM output into the owner's rdata only, so
  // the other port's returned data is never disturbed. A grant in the same
  // edge loads the next command; mem_addr/mem_wdata otherwise hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner       <= 1'b0;
      cmd_we      <= 1'b0;
      p0_gnt_q    <= 1'b0;
      p1_gnt_q    <= 1'b0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      p0_gnt_q    <= 1'b0;
      p1_gnt_q    <= 1'b0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      if (state == DATA && !cmd_we) begin
        if (owner) begin
          p1_rdata_q  <= bus.mem_rdata;
          p1_rvalid_q <= 1'b1;
        end else begin
          p0_rdata_q  <= bus.mem_rdata;
          p0_rvalid_q <= 1'b1;
        end
      end
      if (grant) begin
        owner       <= grant_sel;
        cmd_we      <= sel_we;
        mem_en_q    <= 1'b1;
        mem_we_q    <= sel_we;
        mem_addr_q  <= sel_addr;
        mem_wdata_q <= sel_wdata;
        p0_gnt_q    <= ~grant_sel;
        p1_gnt_q    <= grant_sel;
      end
    end
  end

`ifdef MEM_ARB_RR_EN
  // Remembers who won the most recent grant for the round-robin tie-break.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_winner <= 1'b1;
    end else if (grant) begin
      last_winner <= grant_sel;
    end
  end
`endif

  assign bus.p0_gnt    = p0_gnt_q;
  assign bus.p1_gnt    = p1_gnt_q;
  assign bus.p0_rvalid = p0_rvalid_q;
  assign bus.p1_rvalid = p1_rvalid_q;
  assign bus.p0_rdata  = p0_rdata_q;
  assign bus.p1_rdata  = p1_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = (state != IDLE);

endmodule
